// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RWAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_L = 1'b1
  } owner_t;

  // Width of the read-latency down-counter; holds RD_LAT-1 for RD_LAT up to 4.
  localparam int LAT_W = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way winner selection between core (req[0]) and loader (req[1]).
// Build option: ARB_FIXED_PRIO_EN makes the core win every tie; otherwise
// ties alternate away from last_owner.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic [1:0] grant,
  output owner_t     winner
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last_owner;
  assign unused_last_owner = logic'(last_owner);
`endif

  // Pick the winner; a lone requester always wins, ties depend on the build.
  always_comb begin
    winner = OWN_C;
    case (req)
      2'b10: winner = OWN_L;
      2'b11: begin
`ifdef ARB_FIXED_PRIO_EN
        winner = OWN_C;
`else
        winner = (last_owner == OWN_C) ? OWN_L : OWN_C;
`endif
      end
      default: winner = OWN_C;
    endcase
    grant = 2'b00;
    if (|req) grant = (winner == OWN_L) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the core (C) and the loader/debug DMA (L).
// One access in flight at a time; read data comes back after RD_LAT cycles
// and is routed to whichever requester owned the access.
// Build option: ARB_FIXED_PRIO_EN (core wins ties, no round-robin state).
//
// state  | meaning
// IDLE   | no access in flight; winner granted combinationally
// ACCESS | single memory strobe cycle with the latched request
// RWAIT  | read issued, counting down remaining memory latency
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  arb_state_t       state, state_nxt;
  owner_t           last_owner, own_q, winner;
  logic [1:0]       req, grant;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [LAT_W-1:0] lat_cnt;
  logic             lat_last;
  logic             resp_fire;

  assign req      = {l_req, c_req};
  // RWAIT ends on the cycle whose decrement brings the counter to zero.
  assign lat_last = (lat_cnt <= LAT_W'(1));

  rr_pick2 u_pick (
    .req        (req),
    .last_owner (last_owner),
    .grant      (grant),
    .winner     (winner)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ACCESS;
      ACCESS:  state_nxt = (we_q || RD_LAT == 1) ? IDLE : RWAIT;
      RWAIT:   if (lat_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; everything is forced low while reset is held so a pending
  // write cannot strobe during reset.
  always_comb begin
    c_gnt     = 1'b0;
    l_gnt     = 1'b0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    busy      = 1'b0;
    resp_fire = 1'b0;
    if (reset) begin
      c_gnt = (state == IDLE) && grant[0];
      l_gnt = (state == IDLE) && grant[1];
      busy  = (state != IDLE);
      if (state == ACCESS) begin
        m_en    = 1'b1;
        m_we    = we_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
      end
      resp_fire = ((state == ACCESS) && !we_q && (RD_LAT == 1)) ||
                  ((state == RWAIT) && lat_last);
    end
  end

  // Round-robin history; constant under fixed priority.
`ifdef ARB_FIXED_PRIO_EN
  assign last_owner = OWN_C;
`else
  always_ff @(posedge clk) begin
    if (!reset)                         last_owner <= OWN_L;
    else if ((state == IDLE) && |req)   last_owner <= winner;
  end
`endif

  // Request capture, latency down-counter and registered response routing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      own_q    <= OWN_C;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lat_cnt  <= '0;
      c_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
      c_rdata  <= '0;
      l_rdata  <= '0;
    end else begin
      if ((state == IDLE) && |req) begin
        own_q   <= winner;
        we_q    <= (winner == OWN_L) ? l_we    : c_we;
        addr_q  <= (winner == OWN_L) ? l_addr  : c_addr;
        wdata_q <= (winner == OWN_L) ? l_wdata : c_wdata;
      end
      if ((state == ACCESS) && !we_q) lat_cnt <= LAT_W'(RD_LAT - 1);
      else if (state == RWAIT)        lat_cnt <= lat_cnt - 1'b1;
      c_rvalid <= resp_fire && (own_q == OWN_C);
      l_rvalid <= resp_fire && (own_q == OWN_L);
      if (resp_fire && (own_q == OWN_C)) c_rdata <= m_rdata;
      if (resp_fire && (own_q == OWN_L)) l_rdata <= m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances share the request
// inputs: index 0 has RD_LAT=1, index 1 RD_LAT=2, index 2 RD_LAT=3. Each has
// its own m_rdata so read data is only correct in its expected sample cycle.
module tb_mem_port_arbiter;

  localparam logic [31:0] JUNK = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, l_req, l_we;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;

  logic        c_gnt[3], c_rvalid[3], l_gnt[3], l_rvalid[3];
  logic        m_en[3], m_we[3], busy[3];
  logic [31:0] c_rdata[3], l_rdata[3], m_addr[3], m_wdata[3], m_rdata[3];

  int n_tests = 0;
  int n_fail  = 0;
  int wait_cyc;
  bit seen;
  bit exp_c;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(g + 1)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .c_req    (c_req),
      .c_we     (c_we),
      .c_addr   (c_addr),
      .c_wdata  (c_wdata),
      .c_gnt    (c_gnt[g]),
      .c_rvalid (c_rvalid[g]),
      .c_rdata  (c_rdata[g]),
      .l_req    (l_req),
      .l_we     (l_we),
      .l_addr   (l_addr),
      .l_wdata  (l_wdata),
      .l_gnt    (l_gnt[g]),
      .l_rvalid (l_rvalid[g]),
      .l_rdata  (l_rdata[g]),
      .m_en     (m_en[g]),
      .m_we     (m_we[g]),
      .m_addr   (m_addr[g]),
      .m_wdata  (m_wdata[g]),
      .m_rdata  (m_rdata[g]),
      .busy     (busy[g])
    );
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b0;
    c_req = 1'b0;
    l_req = 1'b0;
    tick;
    tick;
    reset = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_ctl%0d", tag, d),
          {25'd0, c_gnt[d], l_gnt[d], c_rvalid[d], l_rvalid[d], m_en[d], m_we[d], busy[d]}, 32'd0);
      chk($sformatf("%s_bus%0d", tag, d),
          c_rdata[d] | l_rdata[d] | m_addr[d] | m_wdata[d], 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    c_req   = 1'b1;
    c_we    = 1'b0;
    c_addr  = 32'h10;
    c_wdata = 32'h0;
    l_req   = 1'b0;
    l_we    = 1'b0;
    l_addr  = 32'h0;
    l_wdata = 32'h0;
    for (int d = 0; d < 3; d++) m_rdata[d] = JUNK;

    // Reset held with a pending core request: every output low.
    tick;
    @(negedge clk) chk_all_zero("rst_a");
    tick;
    @(negedge clk) chk_all_zero("rst_b");

    // Core read on the RD_LAT=2 instance, granted in the first cycle out of reset.
    tick;
    reset = 1'b1;
    @(negedge clk);
    chk("rd_c_gnt", c_gnt[1], 1'b1);
    chk("rd_l_gnt", l_gnt[1], 1'b0);
    tick;
    c_req = 1'b0;
    @(negedge clk);
    chk("rd_m_en", m_en[1], 1'b1);
    chk("rd_m_we", m_we[1], 1'b0);
    chk("rd_m_addr", m_addr[1], 32'h10);
    chk("rd_busy", busy[1], 1'b1);
    chk("rd_gnt_busy", c_gnt[1], 1'b0);
    tick;
    m_rdata[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd_early_rvalid", c_rvalid[1], 1'b0);
    chk("rd_wait_m_en", m_en[1], 1'b0);
    tick;
    m_rdata[1] = JUNK;
    @(negedge clk);
    chk("rd_rvalid", c_rvalid[1], 1'b1);
    chk("rd_rdata", c_rdata[1], 32'hDEAD_BEEF);
    chk("rd_l_rvalid", l_rvalid[1], 1'b0);
    chk("rd_l_rdata", l_rdata[1], 32'h0);
    chk("rd_busy_done", busy[1], 1'b0);
    tick;
    @(negedge clk);
    chk("rd_pulse_end", c_rvalid[1], 1'b0);
    chk("rd_rdata_hold", c_rdata[1], 32'hDEAD_BEEF);

    // Loader write.
    do_reset;
    tick;
    l_req   = 1'b1;
    l_we    = 1'b1;
    l_addr  = 32'h40;
    l_wdata = 32'h13;
    @(negedge clk);
    chk("wr_l_gnt", l_gnt[1], 1'b1);
    chk("wr_c_gnt", c_gnt[1], 1'b0);
    chk("wr_busy_idle", busy[1], 1'b0);
    tick;
    l_req = 1'b0;
    @(negedge clk);
    chk("wr_m_en", m_en[1], 1'b1);
    chk("wr_m_we", m_we[1], 1'b1);
    chk("wr_m_addr", m_addr[1], 32'h40);
    chk("wr_m_wdata", m_wdata[1], 32'h13);
    tick;
    @(negedge clk);
    chk("wr_busy_drop", busy[1], 1'b0);
    chk("wr_m_we_off", m_we[1], 1'b0);
    chk("wr_no_rvalid", l_rvalid[1], 1'b0);

    // Contention with both requesters writing continuously.
    tick;
    c_req   = 1'b1;
    c_we    = 1'b1;
    c_addr  = 32'h100;
    c_wdata = 32'hC0;
    l_req   = 1'b1;
    l_we    = 1'b1;
    l_addr  = 32'h200;
    l_wdata = 32'hA0;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_c = 1'b1;
`else
      exp_c = (i % 2 == 0);
`endif
      @(negedge clk);
      chk($sformatf("ct_c_gnt%0d", i), c_gnt[1], exp_c);
      chk($sformatf("ct_l_gnt%0d", i), l_gnt[1], !exp_c);
      tick;
      @(negedge clk);
      chk($sformatf("ct_m_addr%0d", i), m_addr[1], exp_c ? 32'h100 : 32'h200);
      chk($sformatf("ct_m_wdata%0d", i), m_wdata[1], exp_c ? 32'hC0 : 32'hA0);
      tick;
    end
    c_req = 1'b0;
    @(negedge clk);
    chk("ct_l_alone", l_gnt[1], 1'b1);
    tick;
    l_req = 1'b0;
    c_we  = 1'b0;
    l_we  = 1'b0;
    tick;

    // Back-to-back core reads on the RD_LAT=1 instance.
    do_reset;
    tick;
    c_req  = 1'b1;
    c_addr = 32'h20;
    @(negedge clk);
    chk("b2b_first_gnt", c_gnt[0], 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick;
      m_rdata[0] = 32'h1111_0000 + 32'(k);
      @(negedge clk);
      chk($sformatf("b2b_m_en%0d", k), m_en[0], 1'b1);
      chk($sformatf("b2b_gnt_off%0d", k), c_gnt[0], 1'b0);
      tick;
      m_rdata[0] = JUNK;
      @(negedge clk);
      chk($sformatf("b2b_rvalid%0d", k), c_rvalid[0], 1'b1);
      chk($sformatf("b2b_rdata%0d", k), c_rdata[0], 32'h1111_0000 + 32'(k));
      chk($sformatf("b2b_gnt%0d", k), c_gnt[0], 1'b1);
    end
    c_req = 1'b0;
    tick;

    // Reset during RWAIT on the RD_LAT=3 instance.
    do_reset;
    tick;
    c_req  = 1'b1;
    c_addr = 32'h30;
    @(negedge clk);
    chk("mr_gnt", c_gnt[2], 1'b1);
    tick;
    c_req = 1'b0;
    @(negedge clk);
    chk("mr_access", m_en[2], 1'b1);
    tick;
    @(negedge clk);
    chk("mr_rwait_busy", busy[2], 1'b1);
    chk("mr_rwait_m_en", m_en[2], 1'b0);
    tick;
    reset      = 1'b0;
    m_rdata[2] = 32'hCAFE_0001;
    tick;
    reset = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (c_rvalid[2] || l_rvalid[2]) seen = 1'b1;
      tick;
    end
    chk("mr_no_rvalid", seen, 1'b0);
    chk("mr_idle", busy[2], 1'b0);
    c_req      = 1'b1;
    c_addr     = 32'h34;
    m_rdata[2] = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("mr_regrant", c_gnt[2], 1'b1);
    tick;
    c_req = 1'b0;
    @(negedge clk);
    chk("mr_re_addr", m_addr[2], 32'h34);
    wait_cyc = 0;
    seen     = 1'b0;
    while (!seen && wait_cyc < 10) begin
      tick;
      wait_cyc++;
      @(negedge clk);
      seen = c_rvalid[2];
    end
    chk("mr_re_rvalid_seen", seen, 1'b1);
    chk("mr_re_latency", wait_cyc, 3);
    chk("mr_re_rdata", c_rdata[2], 32'h5A5A_5A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multicycle RISC-V system between two requesters.
- Requester C is the core's Adr/MemWrite/WriteData/ReadData port. Requester L is the program loader/debug DMA.
- Exactly one access is in flight at a time. Reads have a fixed memory latency. Responses are routed back to the granted requester.
- Sits between the core/loader and the memory model/BRAM.

Parameters:
AW, 32, address width
DW, 32, data width
RD_LAT, 1, memory read latency in cycles from m_en to valid m_rdata (legal 1..4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
c_req  in  1  core request
c_we  in  1  core write enable (1 = write)
c_addr  in  AW  core address
c_wdata  in  DW  core write data
c_gnt  out  1  core request accepted this cycle
c_rvalid  out  1  core read data valid (1-cycle pulse)
c_rdata  out  DW  core read data
l_req, l_we, l_addr, l_wdata  in  1/1/AW/DW  loader request, same meaning as the core fields
l_gnt, l_rvalid  out  1  loader grant / read valid
l_rdata  out  DW  loader read data
m_en  out  1  memory access strobe
m_we  out  1  memory write enable
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data
busy  out  1  access in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low, on the port named reset.
- Reset values (reset==0 at a clk edge): state=IDLE, last_owner=L, lat_cnt=0. All outputs are 0: gnt, rvalid, m_en, m_we, busy, and the rdata/addr/wdata buses.
- States: IDLE, ACCESS, RWAIT.
- IDLE:
  - The winner is chosen combinationally from c_req/l_req.
  - Its gnt is asserted in the same cycle. gnt is only ever high in IDLE.
  - At the clock edge the winner's we/addr/wdata and owner are latched, and the FSM goes to ACCESS.
  - With no request, the FSM stays in IDLE.
- ACCESS (exactly 1 cycle):
  - m_en=1, with m_we/m_addr/m_wdata driven from the latched values.
  - A write returns to IDLE.
  - A read loads lat_cnt=RD_LAT-1. If RD_LAT==1 it goes straight to the response; otherwise it goes to RWAIT.
- RWAIT: lat_cnt decrements each cycle. At 0, the response is issued and the FSM returns to IDLE.
- Response:
  - Registered. owner_rvalid=1 and owner_rdata=m_rdata are sampled exactly RD_LAT cycles after the ACCESS cycle, as a single 1-cycle pulse.
  - The other requester's rvalid stays 0 and its rdata holds its previous value.
- Throughput: a write occupies 2 cycles (IDLE+ACCESS). A read occupies RD_LAT+1 cycles before the next grant can occur, and the next gnt may fall in the same cycle as rvalid.
- Arbitration:
  - Two-way round-robin.
  - A single requester always wins.
  - When both request, the winner is the opposite of last_owner. last_owner updates on every grant.
  - Reset value L means C wins the first tie.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt.
  - It may drop req before gnt with no side effect.
  - req still high in the cycle after gnt is a new request.
- Requests arriving while busy wait; they are not lost as long as they are held.
- m_rdata is ignored outside the sampling cycle. m_we=0 whenever m_en=0.
- Reset mid-operation: the in-flight access is abandoned, no rvalid is issued, and any memory write not yet strobed is not performed.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: the core always wins ties. last_owner is unused (a constant 0).
- Not defined: round-robin as above.
- Single-requester behaviour is identical in both builds.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, ACCESS, RWAIT}
  - owner_t enum {OWN_C, OWN_L}
  - localparam LAT_W = 2 (lat_cnt width)
- Sub-module rr_pick2:
  - Inputs: req[1:0], last_owner. Outputs: grant one-hot [1:0], winner.
  - Purely combinational.
  - Contains the ARB_FIXED_PRIO_EN switch.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles with c_req=1 → all outputs 0. Release → c_gnt in the first cycle reset==1.
- Core read, RD_LAT=2: c_req, addr 0x10, memory returns 0xDEADBEEF → c_gnt at T, m_en/m_addr=0x10 at T+1, c_rvalid=1 with c_rdata=0xDEADBEEF at T+3. l_rvalid stays 0.
- Loader write: l_we=1, addr 0x40, data 0x00000013 → l_gnt at T, then m_en=m_we=1 with addr 0x40 and data 0x13 at T+1. busy drops at T+2.
- Contention: c_req and l_req both held for 4 accesses → grants alternate C, L, C, L (round-robin build). With ARB_FIXED_PRIO_EN, all C until c_req drops.
- Back-to-back reads, RD_LAT=1: c_req held → next c_gnt coincides with the c_rvalid cycle. One access every 2 cycles.
- Reset mid-read, RD_LAT=3: reset asserted during RWAIT → no c_rvalid ever. state=IDLE, and the next request is granted normally.
